// File: rtl/nor_sim_pkg.sv
// Shared constants and helpers for the clocked gate-bank simulation models.
package nor_sim_pkg;

   localparam int unsigned MAX_DELAY_CYCLES     = 15;
   localparam int unsigned MAX_INPUTS           = 8;

   // Defaults shared by the nor, nand and inverter banks.
   localparam int unsigned DEFAULT_DELAY_CYCLES = 1;
   localparam int unsigned DEFAULT_OSC_LIMIT    = 4;
   localparam logic        DEFAULT_IV_BIT       = 1'b0;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage : nor_sim_pkg

// File: rtl/nor_gate_chan.sv
// One NOR channel: delay line, settle rule, consecutive-toggle counter and sticky flag.
module nor_gate_chan
   import nor_sim_pkg::*;
#(
   parameter int unsigned INPUTS       = 3,
   parameter int unsigned DELAY_CYCLES = DEFAULT_DELAY_CYCLES,
   parameter logic        IV           = DEFAULT_IV_BIT,
   parameter int unsigned OSC_LIMIT    = DEFAULT_OSC_LIMIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [INPUTS-1:0] in_i,
   input  logic              settle_en_i,
   input  logic              osc_clr_i,
   output logic              y_o,
   output logic              osc_flag_o
);

   localparam int unsigned CNT_W = clog2(OSC_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(OSC_LIMIT);

   logic             result_c;
   logic             cand_c;
   logic             y_q, y_d;
   logic             prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
   logic             osc_flag_q, osc_flag_d;
   logic             set_c;

   assign result_c = ~|in_i;

   // d[0] holds the newest result; the oldest stage feeds the y register.
   if (DELAY_CYCLES > 1) begin : g_dly
      logic [DELAY_CYCLES-2:0] d_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) d_q <= {(DELAY_CYCLES-1){IV}};
         else        d_q <= (DELAY_CYCLES-1)'({d_q, result_c});
      end

      assign cand_c = d_q[DELAY_CYCLES-2];
   end else begin : g_nodly
      assign cand_c = result_c;
   end

   always_comb begin
      y_d        = cand_c;
      cnt_inc_c  = '0;
      cnt_d      = '0;
      osc_flag_d = osc_flag_q;
      set_c      = 1'b0;

      // Settle: refuse an immediate bounce back away from IV.
      if (settle_en_i && (cand_c == prev_q) && (y_q == IV)) y_d = IV;

      if (y_d != y_q) cnt_inc_c = (cnt_q == CNT_LIM) ? cnt_q : cnt_q + CNT_W'(1);
      set_c = (cnt_q != CNT_LIM) && (cnt_inc_c == CNT_LIM);
      cnt_d = cnt_inc_c;

      if (osc_clr_i) begin
         cnt_d      = '0;
         osc_flag_d = 1'b0;
      end
      // A flag being raised outranks a simultaneous clear.
      if (set_c) begin
         cnt_d      = CNT_LIM;
         osc_flag_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q        <= IV;
         prev_q     <= IV;
         cnt_q      <= '0;
         osc_flag_q <= 1'b0;
      end else begin
         y_q        <= y_d;
         prev_q     <= y_q;
         cnt_q      <= cnt_d;
         osc_flag_q <= osc_flag_d;
      end
   end

   assign y_o        = y_q;
   assign osc_flag_o = osc_flag_q;

endmodule : nor_gate_chan

// File: rtl/nor_gate_bank.sv
// Bank of independent clocked NOR gates with per-channel oscillation detection.
module nor_gate_bank
   import nor_sim_pkg::*;
#(
   parameter int unsigned          CHANNELS     = 8,
   parameter int unsigned          INPUTS       = 3,
   parameter int unsigned          DELAY_CYCLES = DEFAULT_DELAY_CYCLES,
   parameter logic [CHANNELS-1:0]  IV           = {CHANNELS{DEFAULT_IV_BIT}},
   parameter int unsigned          OSC_LIMIT    = DEFAULT_OSC_LIMIT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CHANNELS*INPUTS-1:0] in,
   input  logic                       settle_en,
   input  logic                       osc_clr,
   output logic [CHANNELS-1:0]        y,
   output logic [CHANNELS-1:0]        osc_flag,
   output logic                       any_osc
);

   logic any_osc_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      nor_gate_chan #(
         .INPUTS       (INPUTS),
         .DELAY_CYCLES (DELAY_CYCLES),
         .IV           (IV[c]),
         .OSC_LIMIT    (OSC_LIMIT)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst),
         .in_i        (in[c*INPUTS +: INPUTS]),
         .settle_en_i (settle_en),
         .osc_clr_i   (osc_clr),
         .y_o         (y[c]),
         .osc_flag_o  (osc_flag[c])
      );
   end

   // Summary flag trails the per-channel flags by one edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) any_osc_q <= 1'b0;
      else      any_osc_q <= |osc_flag;
   end

   assign any_osc = any_osc_q;

endmodule : nor_gate_bank

// File: tb/tb_nor_gate_bank.sv
// Random and feedback-loop stimulus for two nor_gate_bank configurations against a queue-based model.
module tb_nor_gate_bank;

   localparam int unsigned    CH   = 8;
   localparam int unsigned    NI   = 3;
   localparam int unsigned    LIM1 = 4;
   localparam int unsigned    LIM3 = 3;
   localparam logic [CH-1:0]  IV1  = 8'hA5;
   localparam logic [CH-1:0]  IV3  = 8'h3C;

   logic             clk;
   logic             rst;
   logic [CH*NI-1:0] in1, in3;
   logic             settle_en, osc_clr;
   logic [CH-1:0]    y1, y3, f1, f3;
   logic             a1, a3;

   int n_checks = 0;
   int n_errors = 0;

   // Model state, index 0 = single-stage bank, index 1 = three-stage bank.
   bit m_y    [2][CH];
   bit m_prev [2][CH];
   bit m_flag [2][CH];
   int m_cnt  [2][CH];
   bit m_any  [2];
   bit m_dq   [2][CH][$];

   nor_gate_bank #(.CHANNELS(CH), .INPUTS(NI), .DELAY_CYCLES(1), .IV(IV1), .OSC_LIMIT(LIM1)) u_d1 (
      .clk(clk), .rst(rst), .in(in1), .settle_en(settle_en), .osc_clr(osc_clr),
      .y(y1), .osc_flag(f1), .any_osc(a1));

   nor_gate_bank #(.CHANNELS(CH), .INPUTS(NI), .DELAY_CYCLES(3), .IV(IV3), .OSC_LIMIT(LIM3)) u_d3 (
      .clk(clk), .rst(rst), .in(in3), .settle_en(settle_en), .osc_clr(osc_clr),
      .y(y3), .osc_flag(f3), .any_osc(a3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dly(int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic int lim(int k);
      return (k == 0) ? int'(LIM1) : int'(LIM3);
   endfunction

   function automatic bit iv_bit(int k, int c);
      logic [CH-1:0] v;
      v = (k == 0) ? IV1 : IV3;
      return v[c];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_any[k] = 1'b0;
         for (int c = 0; c < CH; c++) begin
            m_y[k][c]    = iv_bit(k, c);
            m_prev[k][c] = iv_bit(k, c);
            m_cnt[k][c]  = 0;
            m_flag[k][c] = 1'b0;
            m_dq[k][c].delete();
            for (int s = 0; s < dly(k) - 1; s++) m_dq[k][c].push_back(iv_bit(k, c));
         end
      end
   endtask

   // One clock edge of the reference: output = result from (delay-1) edges ago, then settle and counting rules.
   task automatic model_edge(input int k, input logic [CH*NI-1:0] vin);
      bit any_n, res, cand, ny, hold_iv, setev;
      int cnt_n;
      any_n = 1'b0;
      for (int c = 0; c < CH; c++) any_n |= m_flag[k][c];
      for (int c = 0; c < CH; c++) begin
         res = (vin[c*NI +: NI] == '0);
         if (dly(k) == 1) cand = res;
         else begin
            cand = m_dq[k][c].pop_front();
            m_dq[k][c].push_back(res);
         end
         hold_iv = settle_en && (cand == m_prev[k][c]) && (m_y[k][c] == iv_bit(k, c));
         ny      = hold_iv ? iv_bit(k, c) : cand;
         cnt_n   = (ny != m_y[k][c]) ? ((m_cnt[k][c] + 1 > lim(k)) ? lim(k) : m_cnt[k][c] + 1) : 0;
         setev   = (m_cnt[k][c] < lim(k)) && (cnt_n == lim(k));
         if (setev)        m_flag[k][c] = 1'b1;
         else if (osc_clr) begin
            m_flag[k][c] = 1'b0;
            cnt_n        = 0;
         end
         m_cnt[k][c]  = cnt_n;
         m_prev[k][c] = m_y[k][c];
         m_y[k][c]    = ny;
      end
      m_any[k] = any_n;
   endtask

   function automatic logic [CH-1:0] pack_y(int k);
      logic [CH-1:0] v;
      for (int c = 0; c < CH; c++) v[c] = m_y[k][c];
      return v;
   endfunction

   function automatic logic [CH-1:0] pack_f(int k);
      logic [CH-1:0] v;
      for (int c = 0; c < CH; c++) v[c] = m_flag[k][c];
      return v;
   endfunction

   task automatic compare_all(input string ph);
      check({ph, " y d1"},    32'(y1), 32'(pack_y(0)));
      check({ph, " flag d1"}, 32'(f1), 32'(pack_f(0)));
      check({ph, " any d1"},  32'(a1), 32'(m_any[0]));
      check({ph, " y d3"},    32'(y3), 32'(pack_y(1)));
      check({ph, " flag d3"}, 32'(f3), 32'(pack_f(1)));
      check({ph, " any d3"},  32'(a3), 32'(m_any[1]));
   endtask

   task automatic step(input string ph);
      model_edge(0, in1);
      model_edge(1, in3);
      @(posedge clk);
      #1;
      compare_all(ph);
   endtask

   // Called just after an edge: reset lands mid-cycle and must act at once.
   task automatic do_reset();
      #3 rst = 1'b0;
      #1;
      model_reset();
      compare_all("reset");
      #2 rst = 1'b1;
   endtask

   task automatic set_loop();
      in1 = '0;
      in3 = '0;
      for (int c = 0; c < CH; c++) begin
         in1[c*NI] = m_y[0][c];
         in3[c*NI] = m_y[1][c];
      end
   endtask

   initial begin
      rst       = 1'b0;
      in1       = '0;
      in3       = '0;
      settle_en = 1'b0;
      osc_clr   = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Flush: IV visible for delay-1 edges, then all-ones from zero inputs.
      for (int i = 0; i < 4; i++) step("flush");

      for (int i = 0; i < 150; i++) begin
         in1       = CH*NI'($urandom);
         in3       = CH*NI'($urandom);
         settle_en = 1'($urandom);
         osc_clr   = ($urandom_range(0, 7) == 0);
         step("random");
      end

      // Alternating drive makes every channel toggle each edge.
      settle_en = 1'b0;
      osc_clr   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in1 = '0;
         in3 = '0;
         for (int c = 0; c < CH; c++) begin
            in1[c*NI] = i[0];
            in3[c*NI] = i[0];
         end
         step("alt");
      end

      // Closed feedback loop with occasional clears and a reset in the middle.
      for (int i = 0; i < 40; i++) begin
         set_loop();
         osc_clr = ($urandom_range(0, 4) == 0);
         step("loop");
         if (i == 20) do_reset();
      end

      settle_en = 1'b1;
      osc_clr   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         set_loop();
         step("settle");
      end

      for (int i = 0; i < 60; i++) begin
         in1       = CH*NI'($urandom);
         in3       = CH*NI'($urandom);
         settle_en = 1'($urandom);
         osc_clr   = ($urandom_range(0, 5) == 0);
         step("random2");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_nor_gate_bank
